// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: default widths, opcode
// values and the controller state encoding.
package exec_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_REG_ADDR_W = 3;
  localparam int DEF_MUL_CYCLES = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_MUL  = 3'd3,
    S_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative unsigned shift-add multiplier. A load captures both
// operands and clears the accumulator; each following cycle retires
// one multiplier bit. busy drops once all N bits have been consumed,
// and prod_hi/prod_lo then hold the full 2W-bit product.
module exec_mul_iter #(
  parameter int W = 16,
  parameter int N = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic [W-1:0] prod_lo,
  output logic [W-1:0] prod_hi
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;

  // Shift-add sequencer: multiplicand moves left, multiplier moves right.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (load) begin
      r_acc    <= '0;
      r_mcand  <= {{W{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy    = r_busy;
  assign prod_lo = r_acc[W-1:0];
  assign prod_hi = r_acc[2*W-1:W];

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute stage between the decoder and the register file.
// IDLE -> READ -> EXEC/MUL -> WB -> IDLE. All outputs are registered;
// the write port and done are only non-zero during WB.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [REG_ADDR_W-1:0] srcA,
  input  logic [REG_ADDR_W-1:0] srcB,
  input  logic [REG_ADDR_W-1:0] dst,
  output logic                  ready,
  output logic [REG_ADDR_W-1:0] regSource1,
  output logic [REG_ADDR_W-1:0] regSource2,
  input  logic [DATA_W-1:0]     data1,
  input  logic [DATA_W-1:0]     data2,
  output logic [REG_ADDR_W-1:0] regDestination,
  output logic [DATA_W-1:0]     writeData,
  output logic                  writeEnable,
  output logic                  done,
  output logic                  zero,
  output logic                  carry
);

  state_t                r_state;
  logic [2:0]            r_op;
  logic [REG_ADDR_W-1:0] r_dst;
  logic [DATA_W-1:0]     r_op_a;
  logic [DATA_W-1:0]     r_op_b;

  logic                  w_load;
  logic                  w_busy;
  logic [DATA_W-1:0]     w_prod_lo;
  logic [DATA_W-1:0]     w_prod_hi;
  logic [DATA_W:0]       w_res;
  logic                  w_to_wb;

  // Single-cycle ALU; the top bit is the carry/borrow for ADD/SUB.
  function automatic logic [DATA_W:0] alu_eval(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_SHL:  return {1'b0, a << b[3:0]};
      OP_SHR:  return {1'b0, a >> b[3:0]};
      default: return '0;
    endcase
  endfunction

  // The multiplier loads straight from the register-file read data while
  // in READ, so its iterations overlap the MUL state and the product is
  // final on the cycle busy drops.
  assign w_load = (r_state == S_READ) && (r_op == OP_MUL);

  exec_mul_iter #(
    .W (DATA_W),
    .N (MUL_CYCLES)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .load    (w_load),
    .a       (data1),
    .b       (data2),
    .busy    (w_busy),
    .prod_lo (w_prod_lo),
    .prod_hi (w_prod_hi)
  );

  // Select the result for write-back and decide when to enter WB.
  always_comb begin
    w_res   = alu_eval(r_op, r_op_a, r_op_b);
    w_to_wb = 1'b0;
    if (r_state == S_MUL) begin
      w_res   = {|w_prod_hi, w_prod_lo};
      w_to_wb = !w_busy;
    end else if (r_state == S_EXEC) begin
      w_to_wb = 1'b1;
    end
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_dst          <= '0;
      r_op_a         <= '0;
      r_op_b         <= '0;
      ready          <= 1'b1;
      regSource1     <= '0;
      regSource2     <= '0;
      regDestination <= '0;
      writeData      <= '0;
      writeEnable    <= 1'b0;
      done           <= 1'b0;
      zero           <= 1'b0;
      carry          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op       <= opcode;
            r_dst      <= dst;
            regSource1 <= srcA;
            regSource2 <= srcB;
            ready      <= 1'b0;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          r_op_a     <= data1;
          r_op_b     <= data2;
          regSource1 <= '0;
          regSource2 <= '0;
          r_state    <= (r_op == OP_MUL) ? S_MUL : S_EXEC;
        end
        S_EXEC, S_MUL: begin
          if (w_to_wb) begin
            writeData      <= w_res[DATA_W-1:0];
            regDestination <= r_dst;
            writeEnable    <= (r_dst != '0);
            done           <= 1'b1;
            zero           <= (w_res[DATA_W-1:0] == '0);
            carry          <= w_res[DATA_W];
            r_state        <= S_WB;
          end
        end
        S_WB: begin
          writeData      <= '0;
          regDestination <= '0;
          writeEnable    <= 1'b0;
          done           <= 1'b0;
          ready          <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Multi-cycle execute stage that sits directly between the instruction decoder and the 8x16 register file (R0 hardwired to zero).
- It accepts one decoded ALU instruction and drives the register-file read addresses. It latches the two operands and computes the result; multiply is iterative shift-add.
- It then drives the register-file write port (writeData, regDestination, writeEnable) for exactly one cycle.

Parameters:
- DATA_W, 16, datapath and register width.
- REG_ADDR_W, 3, register index width (8 registers).
- MUL_CYCLES, 16, iterations of the shift-add multiplier (must equal DATA_W).

Ports:
- clock  in  1  single system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- start  in  1  decoder requests execution; accepted only when ready=1.
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- srcA  in  REG_ADDR_W  first source register index.
- srcB  in  REG_ADDR_W  second source register index.
- dst  in  REG_ADDR_W  destination register index.
- ready  out  1  high in IDLE only.
- regSource1  out  REG_ADDR_W  to register file read port 1.
- regSource2  out  REG_ADDR_W  to register file read port 2.
- data1  in  DATA_W  register file read data 1 (combinational from regSource1).
- data2  in  DATA_W  register file read data 2.
- regDestination  out  REG_ADDR_W  to register file write address.
- writeData  out  DATA_W  to register file write data.
- writeEnable  out  1  one-cycle write strobe.
- done  out  1  one-cycle completion pulse, coincident with the WB state.
- zero  out  1  result==0, updated at WB, held until next WB.
- carry  out  1  carry/borrow/overflow flag, updated at WB, held.

Behaviour:
- Reset values: all outputs 0 except ready=1; FSM=IDLE; operand/result/flag registers 0.
- Reset mid-operation: abort immediately; no writeEnable is issued for the aborted instruction.
- States and transitions:
  - IDLE: ready=1. When start=1, capture opcode/srcA/srcB/dst, then go to READ. When start=0, stay in IDLE.
  - READ: regSource1=srcA_q and regSource2=srcB_q (0 in all other states). Latch data1/data2 into opA/opB at the clock edge. Go to EXEC if opcode≠111, else go to MUL.
  - EXEC: compute a DATA_W+1-bit result into result_q/carry_q, then go to WB.
  - MUL: iterative shift-add, one multiplier bit per cycle, with a counter from 0 to MUL_CYCLES-1. After the last iteration go to WB.
  - WB: drive writeData=result_q and regDestination=dst_q. Assert writeEnable=1 only if dst_q≠0 (R0 writes suppressed here too). Pulse done=1 unconditionally. Update zero/carry. Go to IDLE.
- Latency (cycle 0 = edge where start is sampled): non-MUL writeEnable/done high during cycle 3; MUL high during cycle 3+MUL_CYCLES (19). Throughput: the next start can be accepted in the cycle after WB.
- start while ready=0: ignored, not queued. srcA/srcB/dst/opcode changes after acceptance have no effect.
- Arithmetic:
  - ADD: carry = bit 16 of the unsigned sum.
  - SUB: result = opA-opB mod 2^16; carry = 1 iff opA<opB (borrow).
  - AND/OR/XOR: carry=0.
  - SHL/SHR: logical shift by opB[3:0]; carry=0; opB[15:4] is ignored.
  - MUL: writeData = low 16 bits of opA*opB (unsigned); carry=1 iff the high 16 bits are nonzero.
- srcA==srcB or dst==srcA: legal. The operands were latched in READ, so the write in WB uses the old register values.
- Outside WB: writeEnable=0, done=0, writeData and regDestination hold 0.

Decomposition:
- Package exec_pkg:
  - opcode localparams (OP_ADD..OP_MUL);
  - FSM state encoding (S_IDLE, S_READ, S_EXEC, S_MUL, S_WB);
  - DATA_W/REG_ADDR_W defaults.
- Sub-module exec_mul_iter:
  - ports clock, reset, load, a, b, busy, prod_lo, prod_hi;
  - 16-cycle shift-add with a 32-bit accumulator;
  - instantiated once and controlled from the MUL state.

Test Plan:
- ADD with carry: data1=16'hFFFF, data2=16'h0002, dst=3 -> cycle 3: writeEnable=1, regDestination=3, writeData=16'h0001, carry=1, zero=0, done=1.
- SUB borrow and zero: 16'h0005-16'h0007 -> writeData=16'hFFFE, carry=1; then 16'h1234-16'h1234 -> writeData=0, zero=1, carry=0.
- MUL latency/overflow: 16'h0100*16'h0100 -> writeEnable exactly in cycle 19, writeData=16'h0000, carry=1; 16'h0012*16'h0034 -> writeData=16'h03A8, carry=0.
- dst=0 with SHL of 16'h0001 by 16'h0014 (effective shift 4) -> done=1, writeEnable=0, zero=0, writeData=16'h0010.
- Busy rejection: start a MUL, then pulse start with ADD during cycles 2-10 -> ready=0 throughout, exactly one WB (the MUL), no second writeEnable.
- Reset mid-MUL: assert reset in cycle 8 -> next cycle ready=1, writeEnable/done=0; no write occurs; a new ADD then completes normally in 3 cycles.
